// File: rtl/operand_byte_loader_if.sv
// Byte-in / word-out handshake bundle for operand_byte_loader.
// The slave modport is the loader side; the master modport is the environment side.
interface operand_byte_loader_if #(
    parameter int LOG2_BYTES_IN = 3
);
    localparam int WORD_W = 8 << LOG2_BYTES_IN;

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_restart;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, in_restart, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_restart, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/operand_byte_loader.sv
// Assembles byte-serial operands into one wide word (byte 0 least significant)
// and hands the completed word downstream over a valid/ready handshake.
module operand_byte_loader #(
    parameter int LOG2_BYTES_IN = 3,
    parameter int CNT_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    operand_byte_loader_if.slave     bus,
    output logic [LOG2_BYTES_IN-1:0] byte_idx,
    output logic [CNT_W-1:0]         word_count
);
    localparam int WORD_W = 8 << LOG2_BYTES_IN;

    localparam logic [LOG2_BYTES_IN-1:0] IDX_ZERO = LOG2_BYTES_IN'(0);
    localparam logic [LOG2_BYTES_IN-1:0] IDX_ONE  = LOG2_BYTES_IN'(1);
    localparam logic [LOG2_BYTES_IN-1:0] IDX_LAST = {LOG2_BYTES_IN{1'b1}};
    localparam logic [CNT_W-1:0]         CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [LOG2_BYTES_IN-1:0] idx_q,   idx_d;
    logic [WORD_W-1:0]        data_q,  data_d;
    logic [CNT_W-1:0]         cnt_q,   cnt_d;

    // Next-state: restart beats everything, otherwise fill bytes or wait for consumption.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (bus.in_restart) begin
            state_d = FILL;
            idx_d   = IDX_ZERO;
        end else begin
            case (state_q)
                FILL: begin
                    if (bus.in_valid) begin
                        data_d[{idx_q, 3'b000} +: 8] = bus.in_data;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = IDX_ZERO;
                            state_d = FULL;
                        end else begin
                            idx_d   = idx_q + IDX_ONE;
                            state_d = FILL;
                        end
                    end else begin
                        state_d = FILL;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        state_d = FILL;
                        cnt_d   = cnt_q + CNT_ONE;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = FILL;
                    idx_d   = IDX_ZERO;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= IDX_ZERO;
            data_q  <= {WORD_W{1'b0}};
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decode the registered state only.
    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign byte_idx      = idx_q;
    assign word_count    = cnt_q;
endmodule

// File: tb/tb_operand_byte_loader.sv
// Bench for operand_byte_loader: directed scenarios plus randomized traffic
// against a byte-array reference model.
module tb_operand_byte_loader;
    localparam int L  = 3;
    localparam int NB = 1 << L;
    localparam int W  = 8 * NB;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [L-1:0]  byte_idx;
    logic [CW-1:0] word_count;

    always #5 clk = ~clk;

    operand_byte_loader_if #(.LOG2_BYTES_IN(L)) bus ();

    operand_byte_loader #(.LOG2_BYTES_IN(L), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .byte_idx   (byte_idx),
        .word_count (word_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: collected bytes, fill position, word-ready flag, consumed count.
    logic [7:0] m_bytes [NB];
    int         m_fill;
    bit         m_full;
    int         m_cnt;

    function automatic logic [W-1:0] m_word();
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < NB; k++) w[8*k +: 8] = m_bytes[k];
        return w;
    endfunction

    task automatic tick();
        if (rst) begin
            for (int k = 0; k < NB; k++) m_bytes[k] = 8'h00;
            m_fill = 0; m_full = 1'b0; m_cnt = 0;
        end else if (bus.in_restart) begin
            m_fill = 0; m_full = 1'b0;
        end else if (!m_full) begin
            if (bus.in_valid) begin
                m_bytes[m_fill] = bus.in_data;
                m_fill++;
                if (m_fill == NB) begin
                    m_fill = 0; m_full = 1'b1;
                end
            end
        end else if (bus.out_ready) begin
            m_full = 1'b0;
            m_cnt  = (m_cnt + 1) % (1 << CW);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit rdy, input bit rs);
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.out_ready  = rdy;
        bus.in_restart = rs;
    endtask

    task automatic test_reset();
        rst = 1'b1; drive(1'b1, 8'h5A, 1'b1, 1'b0);
        tick(); tick();
        rst = 1'b0; drive(1'b0, 8'h00, 1'b0, 1'b0);
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++;
            $display("FAIL reset_hs got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid, bus.in_ready); end
        total++; if (bus.out_data !== {W{1'b0}} || byte_idx !== 3'd0 || word_count !== 8'd0) begin bad++;
            $display("FAIL reset_regs got data=%h idx=%0d cnt=%0d exp 0/0/0", bus.out_data, byte_idx, word_count); end
    endtask

    task automatic test_fill_hold_consume();
        for (int i = 0; i < NB; i++) begin
            drive(1'b1, 8'(i + 1), 1'b0, 1'b0);
            total++; if (bus.out_valid !== 1'b0) begin bad++;
                $display("FAIL fill_early_valid byte=%0d got=%b exp=0", i, bus.out_valid); end
            tick();
        end
        total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin bad++;
            $display("FAIL fill_full_hs got valid=%b ready=%b exp 1/0", bus.out_valid, bus.in_ready); end
        total++; if (bus.out_data !== 64'h0807060504030201) begin bad++;
            $display("FAIL fill_word got=%h exp=%h", bus.out_data, 64'h0807060504030201); end
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        total++; if (bus.out_data !== 64'h0807060504030201 || byte_idx !== 3'd0 || bus.out_valid !== 1'b1) begin bad++;
            $display("FAIL hold got data=%h idx=%0d valid=%b exp 0807060504030201/0/1", bus.out_data, byte_idx, bus.out_valid); end
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || word_count !== 8'd1) begin bad++;
            $display("FAIL consume got valid=%b ready=%b cnt=%0d exp 0/1/1", bus.out_valid, bus.in_ready, word_count); end
    endtask

    task automatic test_restart();
        logic [7:0] seq [3];
        seq[0] = 8'hAA; seq[1] = 8'hBB; seq[2] = 8'hCC;
        for (int i = 0; i < 3; i++) begin drive(1'b1, seq[i], 1'b0, 1'b0); tick(); end
        total++; if (byte_idx !== 3'd3) begin bad++;
            $display("FAIL restart_pre_idx got=%0d exp=3", byte_idx); end
        drive(1'b1, 8'hDD, 1'b1, 1'b1);
        tick();
        total++; if (byte_idx !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_data[7:0] !== 8'hAA) begin bad++;
            $display("FAIL restart got idx=%0d valid=%b b0=%h exp 0/0/aa", byte_idx, bus.out_valid, bus.out_data[7:0]); end
        for (int i = 0; i < NB; i++) begin drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0); tick(); end
        total++; if (bus.out_data !== 64'h1716151413121110 || bus.out_valid !== 1'b1) begin bad++;
            $display("FAIL restart_word got=%h valid=%b exp=1716151413121110 valid=1", bus.out_data, bus.out_valid); end
        drive(1'b1, 8'h33, 1'b1, 1'b1);
        tick();
        total++; if (bus.out_valid !== 1'b0 || word_count !== 8'd1) begin bad++;
            $display("FAIL restart_full got valid=%b cnt=%0d exp 0/1", bus.out_valid, word_count); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_gapped();
        for (int i = 0; i < NB; i++) begin
            drive(1'b1, 8'(i + 1), 1'b0, 1'b0); tick();
            if (i < NB - 1) begin
                total++; if (bus.out_valid !== 1'b0 || byte_idx !== 3'(i + 1)) begin bad++;
                    $display("FAIL gap_byte i=%0d got valid=%b idx=%0d exp 0/%0d", i, bus.out_valid, byte_idx, i + 1); end
                drive(1'b0, 8'hEE, 1'b0, 1'b0); tick();
                total++; if (bus.out_valid !== 1'b0 || byte_idx !== 3'(i + 1)) begin bad++;
                    $display("FAIL gap_idle i=%0d got valid=%b idx=%0d exp 0/%0d", i, bus.out_valid, byte_idx, i + 1); end
            end
        end
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0807060504030201) begin bad++;
            $display("FAIL gap_word got valid=%b data=%h exp 1/0807060504030201", bus.out_valid, bus.out_data); end
        drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
        total++; if (word_count !== 8'd2) begin bad++;
            $display("FAIL gap_cnt got=%0d exp=2", word_count); end
    endtask

    task automatic test_back_to_back();
        int  consumed = 0;
        int  last_rise = -1;
        bit  prev_v = 1'b0;
        bit  saw_zero = 1'b0;
        int  start_cnt = m_cnt;
        for (int n = 0; n < 256 * (NB + 1) + 40 && consumed < 256; n++) begin
            drive(1'b1, 8'($urandom), 1'b1, 1'b0);
            if (bus.out_valid && bus.out_ready) consumed++;
            tick();
            if (bus.out_valid && !prev_v) begin
                if (last_rise >= 0) begin
                    total++; if (cyc - last_rise !== NB + 1) begin bad++;
                        $display("FAIL b2b_spacing got=%0d exp=%0d", cyc - last_rise, NB + 1); end
                end
                total++; if (bus.out_data !== m_word()) begin bad++;
                    $display("FAIL b2b_word got=%h exp=%h", bus.out_data, m_word()); end
                last_rise = cyc;
            end
            if (word_count === 8'd0) saw_zero = 1'b1;
            prev_v = bus.out_valid;
        end
        total++; if (consumed != 256) begin bad++;
            $display("FAIL b2b_budget got=%0d exp=256", consumed); end
        total++; if (word_count !== 8'((start_cnt + 256) % 256) || !saw_zero) begin bad++;
            $display("FAIL b2b_wrap got=%0d saw_zero=%b exp=%0d saw_zero=1", word_count, saw_zero, (start_cnt + 256) % 256); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 29) == 0));
            tick();
            total++;
            if (bus.out_valid !== m_full || bus.in_ready !== !m_full || byte_idx !== 3'(m_fill) ||
                word_count !== 8'(m_cnt) || bus.out_data !== m_word()) begin
                bad++;
                $display("FAIL rand n=%0d got v=%b r=%b idx=%0d cnt=%0d d=%h exp v=%b r=%b idx=%0d cnt=%0d d=%h",
                         n, bus.out_valid, bus.in_ready, byte_idx, word_count, bus.out_data,
                         m_full, !m_full, m_fill, m_cnt, m_word());
            end
        end
    endtask

    task automatic test_reset_while_full();
        drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
        for (int i = 0; i < NB; i++) begin drive(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0); tick(); end
        total++; if (bus.out_valid !== 1'b1) begin bad++;
            $display("FAIL rstfull_pre got valid=%b exp=1", bus.out_valid); end
        rst = 1'b1; drive(1'b1, 8'h77, 1'b1, 1'b0); tick();
        rst = 1'b0; drive(1'b0, 8'h00, 1'b0, 1'b0);
        total++; if (bus.out_valid !== 1'b0 || bus.out_data !== {W{1'b0}} || word_count !== 8'd0 || byte_idx !== 3'd0) begin bad++;
            $display("FAIL rstfull got valid=%b data=%h cnt=%0d idx=%0d exp 0/0/0/0", bus.out_valid, bus.out_data, word_count, byte_idx); end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_fill_hold_consume();
        test_restart();
        test_gapped();
        test_back_to_back();
        test_random();
        test_reset_while_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
